// File: rtl/instr_fetch_if.sv
// Bundles the instruction-memory request channel, the redirect input and the
// decode-side valid/ready channel of the fetch stage.
// master: the fetch stage itself. slave: memory, redirect source and decode.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic        redirect;
   logic [31:0] redirect_pc;

   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] pc_4;
   logic [31:0] fetch_count;

   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_rdata,
      input  redirect, redirect_pc,
      output instr_valid,
      input  instr_ready,
      output instr, pc_4, fetch_count
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_rdata,
      output redirect, redirect_pc,
      input  instr_valid,
      output instr_ready,
      input  instr, pc_4, fetch_count
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory request at a time, no
// prefetch. The fetched word and its PC+4 are held for decode until accepted.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, first request issued on the next edge
// REQ   | request for pc outstanding on imem
// FLUSH | redirected while a request was in flight; wait for its ack,
//       | throw the data away, then fetch from tgt
// OUT   | instr/pc_4 valid towards decode, waiting for instr_ready
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst_n,
   instr_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FLUSH = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] pc;
   logic [31:0] tgt;
   logic [31:0] instr_q;
   logic [31:0] pc_4_q;
   logic [31:0] fetch_count_q;
   logic [31:0] redirect_tgt;
   logic [31:0] pc_inc;

   assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
   assign pc_inc       = pc + 32'd4;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            state_nxt = REQ;
         end
         REQ: begin
            if (bus.imem_ack) begin
               state_nxt = bus.redirect ? REQ : OUT;
            end else if (bus.redirect) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (bus.imem_ack) begin
               state_nxt = REQ;
            end
         end
         OUT: begin
            if (bus.redirect || bus.instr_ready) begin
               state_nxt = REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Outputs decoded from state only, so redirect/instr_ready never reach
   // instr_valid combinationally. pc is left untouched while a flushed fetch
   // drains, so it doubles as the abandoned address in FLUSH.
   always_comb begin
      bus.imem_req    = (state == REQ) || (state == FLUSH);
      bus.imem_addr   = pc;
      bus.instr_valid = (state == OUT);
      bus.instr       = instr_q;
      bus.pc_4        = pc_4_q;
      bus.fetch_count = fetch_count_q;
   end

   // Program counter, pending redirect target, fetched word and accept counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_PC;
         tgt           <= 32'h0000_0000;
         instr_q       <= 32'h0000_0000;
         pc_4_q        <= 32'h0000_0000;
         fetch_count_q <= 32'h0000_0000;
      end else begin
         case (state)
            REQ: begin
               if (bus.imem_ack) begin
                  if (bus.redirect) begin
                     pc <= redirect_tgt;
                  end else begin
                     instr_q <= bus.imem_rdata;
                     pc_4_q  <= pc_inc;
                     pc      <= pc_inc;
                  end
               end else if (bus.redirect) begin
                  tgt <= redirect_tgt;
               end
            end
            FLUSH: begin
               if (bus.redirect) begin
                  tgt <= redirect_tgt;
               end
               if (bus.imem_ack) begin
                  pc <= bus.redirect ? redirect_tgt : tgt;
               end
            end
            OUT: begin
               if (bus.redirect) begin
                  pc <= redirect_tgt;
               end else if (bus.instr_ready) begin
                  fetch_count_q <= fetch_count_q + 32'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: holds the program counter, fetches one 32-bit word per request from instruction memory over a req/ack handshake, and presents the instruction plus PC+4 to the decode stage over a valid/ready handshake. It sits between instruction memory and the decode stage, which consumes `instr` and `pc_4`. It also accepts branch/jump redirects from later stages. There is one outstanding memory request at most, and no prefetch, so peak throughput is one instruction per two cycles.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; low 2 bits must be 0.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: memory request. Combinational from state.
- `imem_addr` out 32: word-aligned fetch address. Stable while `imem_req`=1.
- `imem_ack` in 1: memory response valid. May arrive in the same cycle as the request or any later cycle.
- `imem_rdata` in 32: instruction word. Sampled only when `imem_req`&`imem_ack`.
- `redirect` in 1: one-cycle pulse that loads a new PC (branch/jump taken).
- `redirect_pc` in 32: redirect target. Bits [1:0] are forced to 0 internally.
- `instr_valid` out 1: `instr`/`pc_4` hold a valid fetched instruction.
- `instr_ready` in 1: decode accepts the instruction this cycle.
- `instr` out 32: registered instruction word to decode.
- `pc_4` out 32: registered address of `instr` + 4.
- `fetch_count` out 32: number of instructions accepted by decode. Wraps modulo 2^32.

## Operation
- States: IDLE, REQ, FLUSH, OUT.
- `imem_req`=1 only in REQ and FLUSH. In REQ, `imem_addr`=pc; in FLUSH, `imem_addr`=the address of the abandoned fetch.
- IDLE: the state entered on reset. Goes to REQ on the first clock edge after `rst_n` rises.
- REQ, no ack:
  - If `redirect`=1: save the target in `tgt`, go to FLUSH. The request cannot be withdrawn.
  - Otherwise stay in REQ.
- REQ, with ack:
  - If `redirect`=1: discard `imem_rdata`, pc<=redirect target, stay in REQ (new address next cycle).
  - Otherwise: `instr`<=`imem_rdata`, `pc_4`<=pc+4, pc<=pc+4, `instr_valid`<=1, go to OUT.
- FLUSH:
  - A `redirect` in this state overwrites `tgt` (latest redirect wins).
  - On ack: discard data, pc<=`tgt`. If `redirect` is asserted in the same cycle, its target wins. Go to REQ.
- OUT: `instr_valid`=1 and `instr`/`pc_4` are held stable.
  - If `redirect`=1: `instr_valid`<=0, pc<=target, go to REQ. The instruction is dropped even if `instr_ready`=1 and is not counted.
  - Else if `instr_ready`=1: `instr_valid`<=0, `fetch_count`+=1, go to REQ.
  - Otherwise hold.
- `instr_valid`=1 only in OUT. `instr_ready` is ignored outside OUT.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). `fetch_count` wraps 32'hFFFF_FFFF -> 0.

## Timing
- Reset values: pc=`RESET_PC`, state=IDLE, `instr`=0, `pc_4`=0, `instr_valid`=0, `fetch_count`=0, `tgt`=0. Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`.
- Reset asserted mid-operation aborts any outstanding request immediately: `imem_req` drops asynchronously. The memory must tolerate this.
- Fetch latency with same-cycle ack: request in cycle t, `instr_valid` in t+1. With ready in t+1, the next request is in t+2.
- A memory ack N cycles after the request delays `instr_valid` by N cycles.
- Redirect in cycle t, in REQ or OUT, puts the new address on `imem_addr` in cycle t+1.
- Redirect in REQ without ack: the new address appears the cycle after the outstanding ack.
- No combinational path exists from `instr_ready` or `redirect` to `instr_valid`, `instr` or `pc_4`.

## Test plan
- Reset release, memory acks same cycle, `instr_ready`=1 always:
  - `imem_addr` sequence 0,4,8,… with a request every other cycle.
  - `pc_4` = 4,8,12,…
  - `fetch_count`=3 after the third handshake.
- Backpressure: hold `instr_ready`=0 for 5 cycles in OUT.
  - `instr_valid`, `instr` and `pc_4` stay stable.
  - `imem_req`=0 throughout.
  - Count increments once on release.
- Memory wait states: ack 3 cycles after req with `imem_rdata`=32'h2108_0001.
  - `imem_addr` stays stable for 4 cycles.
  - `instr`=32'h2108_0001 the cycle after the ack.
- Redirect to 32'h0000_0043 in REQ before ack, then a second redirect to 32'h0000_0100 in FLUSH.
  - First ack data is discarded.
  - The next request address is 32'h0000_0100.
  - `instr_valid` stays 0 until that fetch completes.
- Redirect and `instr_ready` together in OUT:
  - Instruction is dropped and `fetch_count` is unchanged.
  - Next `imem_addr`=redirect target.
- Wrap-around: `RESET_PC`=32'hFFFF_FFFC.
  - First `pc_4`=0, second `imem_addr`=0.
  - Assert reset mid-FLUSH: `imem_req` drops at once, and the first address after release is `RESET_PC`.
